sar_adc_scan_ctrl: RTL and testbench

- Parametrised successor to the single fixed 8-bit ADC test circuit: a multi-channel successive-approximation ADC controller for mixed-signal co-simulation.
- Drives an external analog input mux, a track/hold switch and a WIDTH-bit capacitive/resistive DAC, all modelled in SPICE. Reads back a single comparator bit.
- Scans the enabled channels in ascending order and delivers one result per channel over a valid/ready stream.
- Adds channel scanning, continuous mode and back-pressure, none of which the 8-bit single-channel block has.

---
 rtl/sar_adc_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sar_adc_scan_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_scan_ctrl.sv
// Multi-channel SAR ADC scan controller: walks the enabled channels in ascending
// order, runs one binary search per channel and hands results out over valid/ready.
//
// state    | meaning
// IDLE     | waiting for start with a non-zero channel mask
// SAMPLE   | one arm cycle after a result (next channel select), then track/hold closed
// CONVERT  | binary search, one bit per SETTLE_CYCLES+1 cycles
// WAIT_OUT | conversion finished, output register still occupied
module sar_adc_scan_ctrl #(
  parameter int WIDTH         = 8,
  parameter int NCH           = 4,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             cmp,
  output logic [CHW-1:0]   mux_sel,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result_data,
  output logic [CHW-1:0]   result_ch,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int CW = $clog2(SAMPLE_CYCLES + SETTLE_CYCLES + 1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, WAIT_OUT} state_t;

  state_t           state_q;
  logic [NCH-1:0]   mask_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bit_q;
  logic             arm_q;
  logic [CHW-1:0]   nxt_ch_q;

  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] fin_code;
  logic [NCH-1:0]   rem_mask;
  logic             can_load;
  logic             done_conv;
  logic             finish;
  logic             last_ch;

  function automatic logic [CHW-1:0] low_idx(input logic [NCH-1:0] m);
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) low_idx = CHW'(i);
  endfunction

  always_comb begin
    decided          = dac_code;
    decided[bit_q]   = cmp;
    trial            = decided;
    if (bit_q != '0) trial[bit_q - BW'(1)] = 1'b1;
    rem_mask = '0;
    for (int i = 0; i < NCH; i++)
      rem_mask[i] = mask_q[i] && (i > int'(mux_sel));
  end

  assign can_load  = !result_valid || result_ready;
  assign done_conv = (state_q == CONVERT) && (cnt_q == '0) && (bit_q == '0);
  assign finish    = (done_conv || (state_q == WAIT_OUT)) && can_load;
  assign fin_code  = (state_q == WAIT_OUT) ? dac_code : decided;
  assign last_ch   = (rem_mask == '0);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      cnt_q        <= '0;
      bit_q        <= '0;
      arm_q        <= 1'b0;
      nxt_ch_q     <= '0;
      mux_sel      <= '0;
      sample       <= 1'b0;
      dac_code     <= '0;
      result_data  <= '0;
      result_ch    <= '0;
      result_valid <= 1'b0;
    end else begin
      if (result_valid && result_ready) result_valid <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q <= ch_mask;
            if (ch_mask != '0) begin
              state_q  <= SAMPLE;
              mux_sel  <= low_idx(ch_mask);
              sample   <= 1'b1;
              dac_code <= '0;
              cnt_q    <= CW'(SAMPLE_CYCLES - 1);
            end
          end
        end
        SAMPLE: begin
          if (arm_q) begin
            arm_q    <= 1'b0;
            mux_sel  <= nxt_ch_q;
            sample   <= 1'b1;
            dac_code <= '0;
            cnt_q    <= CW'(SAMPLE_CYCLES - 1);
          end else if (cnt_q == '0) begin
            state_q  <= CONVERT;
            sample   <= 1'b0;
            dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
            bit_q    <= BW'(WIDTH - 1);
            cnt_q    <= CW'(SETTLE_CYCLES);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        CONVERT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (bit_q != '0) begin
            dac_code <= trial;
            bit_q    <= bit_q - BW'(1);
            cnt_q    <= CW'(SETTLE_CYCLES);
          end else begin
            dac_code <= decided;
            if (!can_load) state_q <= WAIT_OUT;
          end
        end
        default: ;
      endcase

      // Result hand-off and advance to the next channel (or wrap / stop)
      if (finish) begin
        result_data  <= fin_code;
        result_ch    <= mux_sel;
        result_valid <= 1'b1;
        if (!last_ch) begin
          state_q  <= SAMPLE;
          arm_q    <= 1'b1;
          nxt_ch_q <= low_idx(rem_mask);
        end else if (cont) begin
          mask_q <= ch_mask;
          if (ch_mask != '0) begin
            state_q  <= SAMPLE;
            arm_q    <= 1'b1;
            nxt_ch_q <= low_idx(ch_mask);
          end else begin
            state_q <= IDLE;
          end
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_scan_ctrl.sv
// Scoreboard bench for sar_adc_scan_ctrl: an 8-bit default instance and a 12-bit,
// zero-settle instance, each driven by a behavioural comparator model.
module tb_sar_adc_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        start0, cont0, cmp0, sample0, valid0, busy0, result_ready;
  logic [3:0]  mask0;
  logic [1:0]  mux_sel0, rch0;
  logic [7:0]  dac0, rdata0;

  logic        start1, cmp1, sample1, valid1, busy1;
  logic        cont1  = 1'b0;
  logic        ready1 = 1'b1;
  logic [3:0]  mask1;
  logic [1:0]  mux_sel1, rch1;
  logic [11:0] dac1, rdata1;

  sar_adc_scan_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0), .ch_mask(mask0), .cmp(cmp0),
    .mux_sel(mux_sel0), .sample(sample0), .dac_code(dac0), .result_data(rdata0),
    .result_ch(rch0), .result_valid(valid0), .result_ready(result_ready), .busy(busy0)
  );

  sar_adc_scan_ctrl #(.WIDTH(12), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .ch_mask(mask1), .cmp(cmp1),
    .mux_sel(mux_sel1), .sample(sample1), .dac_code(dac1), .result_data(rdata1),
    .result_ch(rch1), .result_valid(valid1), .result_ready(ready1), .busy(busy1)
  );

  // Analog inputs in half-LSB units; mode 0 = ideal, 1 = stuck high, 2 = stuck low
  int vin2 [4];
  int mode0 = 0;
  int mode1 = 1;

  always_comb begin
    if (mode0 == 1)      cmp0 = 1'b1;
    else if (mode0 == 2) cmp0 = 1'b0;
    else                 cmp0 = (vin2[mux_sel0] > 2 * int'(dac0));
  end
  assign cmp1 = (mode1 == 1);

  int n_tests = 0;
  int n_fail  = 0;
  int start_cyc = 0;
  int q0[$];
  int q1[$];
  int hs_times[$];
  logic [3:0] sampled_mask = '0;
  logic ready_rand  = 1'b0;
  logic ready_level = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ideal SAR result: the largest code strictly below Vin, clamped to full scale
  function automatic int sar_ref(input int mode, input int v2, input int width);
    int maxc = (1 << width) - 1;
    if (mode == 1) return maxc;
    if (mode == 2) return 0;
    return (v2 / 2 > maxc) ? maxc : v2 / 2;
  endfunction

  task automatic push_scan(input logic [3:0] m);
    for (int c = 0; c < 4; c++)
      if (m[c]) q0.push_back((c << 16) | sar_ref(mode0, vin2[c], 8));
  endtask

  task automatic pulse_start0(input logic [3:0] m);
    @(posedge clk); #1;
    mask0 = m; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start_cyc = cyc;
  endtask

  task automatic at_edge(input int k);
    @(negedge clk);
    while (cyc < start_cyc + k) @(negedge clk);
  endtask

  task automatic wait_idle0(input string name, input int budget);
    int k = 0;
    while ((busy0 || q0.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s: timeout, busy=%0d pending=%0d", name, busy0, q0.size());
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_mux"},   int'(mux_sel0), 0);
    check({name, "_samp"},  int'(sample0),  0);
    check({name, "_dac"},   int'(dac0),     0);
    check({name, "_data"},  int'(rdata0),   0);
    check({name, "_ch"},    int'(rch0),     0);
    check({name, "_valid"}, int'(valid0),   0);
    check({name, "_busy"},  int'(busy0),    0);
  endtask

  task automatic run_dut1(input int mode, input int exp);
    int k = 0;
    mode1 = mode;
    q1.push_back(exp);
    @(posedge clk); #1;
    mask1 = 4'b0001; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start_cyc = cyc;
    at_edge(15);
    check("w12_valid_e15", int'(valid1), 0);
    at_edge(16);
    check("w12_valid_e16", int'(valid1), 1);
    while ((busy1 || q1.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("w12_drain", int'(k < 100), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    rst_n = 1'b0; start0 = 1'b0; cont0 = 1'b0; mask0 = '0;
    start1 = 1'b0; mask1 = '0; result_ready = 1'b0;
    for (int c = 0; c < 4; c++) vin2[c] = 1;

    fork
      forever begin
        @(posedge clk); #1;
        result_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
      end
      begin : mon0
        logic pv = 1'b0, pr = 1'b0;
        int prev = 0, act = 0, e = 0;
        forever begin
          @(negedge clk);
          act = (int'(rch0) << 16) | int'(rdata0);
          if (!rst_n) begin
            pv = 1'b0;
          end else begin
            if (sample0) sampled_mask[mux_sel0] = 1'b1;
            if (pv && !pr) begin
              check("hold_valid", int'(valid0), 1);
              check("hold_data", act, prev);
            end
            if (valid0 && result_ready) begin
              hs_times.push_back(cyc);
              if (q0.size() == 0) begin
                check("unexpected_result", act, -1);
              end else begin
                e = q0.pop_front();
                check("result", act, e);
              end
            end
            pv = valid0; pr = result_ready; prev = act;
          end
        end
      end
      forever begin
        @(negedge clk);
        if (rst_n && valid1) begin
          if (q1.size() == 0) check("w12_unexpected", int'(rdata1), -1);
          else check("w12_result", int'(rdata1), q1.pop_front());
        end
      end
    join_none

    #2;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // Single channel, ideal comparator, Vin = 165.5 LSB
    vin2[0] = 331;
    push_scan(4'b0001);
    pulse_start0(4'b0001);
    at_edge(0);
    check("t1_sample_e0", int'(sample0), 1);
    check("t1_mux", int'(mux_sel0), 0);
    check("t1_busy", int'(busy0), 1);
    at_edge(3);
    check("t1_sample_e3", int'(sample0), 1);
    at_edge(4);
    check("t1_sample_e4", int'(sample0), 0);
    check("t1_dac_msb", int'(dac0), 'h80);
    at_edge(6);
    check("t1_dac_bit6", int'(dac0), 'hC0);
    at_edge(19);
    check("t1_valid_e19", int'(valid0), 0);
    at_edge(20);
    check("t1_valid_e20", int'(valid0), 1);
    check("t1_data", int'(rdata0), 'hA5);
    at_edge(21);
    check("t1_busy_after", int'(busy0), 0);
    wait_idle0("t1_idle", 100);

    // Two channels, 1 and 3
    vin2[1] = 21; vin2[3] = 401;
    sampled_mask = '0;
    push_scan(4'b1010);
    pulse_start0(4'b1010);
    wait_idle0("t2_idle", 200);
    check("t2_sampled", int'(sampled_mask), 'b1010);

    // Back-pressure: a pending ch0 result forces ch1 to wait in WAIT_OUT
    ready_level = 1'b0;
    repeat (3) @(posedge clk);
    push_scan(4'b0001);
    pulse_start0(4'b0001);
    at_edge(22);
    check("t3_a_valid", int'(valid0), 1);
    check("t3_a_busy", int'(busy0), 0);
    sampled_mask = '0;
    push_scan(4'b1010);
    pulse_start0(4'b1010);
    at_edge(55);
    check("t3_wait_dac", int'(dac0), 'h0A);
    check("t3_wait_sample", int'(sample0), 0);
    check("t3_wait_busy", int'(busy0), 1);
    check("t3_held_data", int'(rdata0), 'hA5);
    check("t3_held_ch", int'(rch0), 0);
    check("t3_sampled_wait", int'(sampled_mask), 'b0010);
    ready_level = 1'b1;
    wait_idle0("t3_idle", 300);
    check("t3_sampled_all", int'(sampled_mask), 'b1010);

    // Stuck comparators, 8-bit and 12-bit instances
    mode0 = 1;
    push_scan(4'b0001);
    pulse_start0(4'b0001);
    wait_idle0("t4_stuck1", 100);
    mode0 = 2;
    push_scan(4'b0001);
    pulse_start0(4'b0001);
    wait_idle0("t4_stuck0", 100);
    mode0 = 0;
    run_dut1(1, 'hFFF);
    run_dut1(2, 'h000);

    // Zero mask: start is accepted but nothing runs
    pulse_start0(4'b0000);
    at_edge(1);
    check("t5_busy_e1", int'(busy0), 0);
    at_edge(6);
    check("t5_busy_e6", int'(busy0), 0);
    check("t5_valid", int'(valid0), 0);

    // start and mask change mid-conversion are ignored
    vin2[0] = 77;
    sampled_mask = '0;
    push_scan(4'b0001);
    pulse_start0(4'b0001);
    at_edge(9);
    start0 = 1'b1; mask0 = 4'b1111;
    @(posedge clk); #1;
    start0 = 1'b0;
    at_edge(21);
    check("t6_busy_after", int'(busy0), 0);
    at_edge(26);
    check("t6_busy_later", int'(busy0), 0);
    wait_idle0("t6_idle", 100);
    check("t6_sampled", int'(sampled_mask), 'b0001);

    // Continuous mode on ch0: results every 21 cycles until cont drops
    vin2[0] = 331;
    hs_times.delete();
    cont0 = 1'b1;
    repeat (3) push_scan(4'b0001);
    pulse_start0(4'b0001);
    begin
      int k = 0;
      while (hs_times.size() < 2 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check("t7_two_results", int'(k < 200), 1);
    end
    cont0 = 1'b0;
    wait_idle0("t7_idle", 200);
    check("t7_count", hs_times.size(), 3);
    if (hs_times.size() == 3) begin
      check("t7_period1", hs_times[1] - hs_times[0], 21);
      check("t7_period2", hs_times[2] - hs_times[1], 21);
    end

    // Asynchronous reset in the middle of a conversion
    push_scan(4'b0001);
    pulse_start0(4'b0001);
    at_edge(9);
    @(posedge clk); #3;
    rst_n = 1'b0;
    q0.delete();
    #1;
    check_outputs_zero("t8_async");
    @(negedge clk); #1;
    rst_n = 1'b1;
    push_scan(4'b0001);
    pulse_start0(4'b0001);
    at_edge(19);
    check("t8_valid_e19", int'(valid0), 0);
    at_edge(20);
    check("t8_valid_e20", int'(valid0), 1);
    check("t8_data", int'(rdata0), 'hA5);
    wait_idle0("t8_idle", 100);

    // Randomised scans with random back-pressure
    ready_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) vin2[c] = int'($urandom_range(0, 512)) | 1;
      mode0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      push_scan(m);
      pulse_start0(m);
      wait_idle0("rand_idle", 2000);
    end
    ready_rand = 1'b0;
    mode0 = 0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
